// File: rtl/mux41_pkg.sv
// Shared types and constants for the 4-way round-robin select arbiter.
// Other 4-way arbiters that reuse rr_pick4 import this package too.
package mux41_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Round-robin successor; the 2-bit width gives the 3 -> 0 wrap for free.
    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Purely combinational 4-way round-robin picker: the first set req bit,
// scanning from ptr upward modulo 4.
module rr_pick4
    import mux41_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] win
);

    logic [SELW-1:0] cand [NREQ];
    logic [NREQ-1:0] hit;

    // Candidate gi is ptr+gi; hit[gi] says that candidate is requesting.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = ptr + SELW'(gi);
        assign hit[gi]  = req[cand[gi]];
    end

    assign any = |req;

    // Scan from the farthest candidate down, so the nearest hit wins.
    always_comb begin
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win = cand[k];
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter with packet locking; it drives a registered 4:1 select
// and presents the granted requester's word on one valid/ready channel.
module mux41_rr_arbiter
    import mux41_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  last,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [NREQ-1:0]  ack,
    output logic [SELW-1:0]  sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            pick_any;
    logic [SELW-1:0] pick_win;
    logic            transfer;
    logic [WIDTH-1:0] mux_data;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        mux_data = i0;
        case (sel_q)
            2'd0:    mux_data = i0;
            2'd1:    mux_data = i1;
            2'd2:    mux_data = i2;
            default: mux_data = i3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = i0;
        ack       = '0;
        transfer  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_win;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                out_valid    = req[sel_q];
                out_data     = mux_data;
                out_last     = last[sel_q] & req[sel_q];
                transfer     = req[sel_q] & out_ready;
                ack[sel_q]   = transfer;
                // Packet end and abandonment both release the lock the same way.
                if ((transfer && last[sel_q]) || !req[sel_q]) begin
                    ptr_d   = next_idx(sel_q);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: walks the single-requester, round-robin,
// lock/back-pressure, abandonment, mid-packet reset and idle scenarios.
module tb_mux41_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [7:0] i0, i1, i2, i3;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux41_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] rr_order [5];
        logic [7:0] rr_data  [4];
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data  = '{8'h10, 8'h20, 8'h30, 8'h40};

        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        tick(); tick();
        rst = 1'b0;
        $display("reset applied");
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_sel",   32'(sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_last",  32'(out_last), 32'd0);

        // Single requester 2
        req = 4'b0100; i2 = 8'hA5; last = 4'b0100; out_ready = 1'b1;
        #1;
        chk("single_idle_valid", 32'(out_valid), 32'd0);
        chk("single_idle_ack",   32'(ack), 32'd0);
        tick();
        $display("single: sel=%0d data=%h ack=%b", sel, out_data, ack);
        chk("single_sel",   32'(sel), 32'd2);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data), 32'hA5);
        chk("single_ack",   32'(ack), 32'b0100);
        chk("single_last",  32'(out_last), 32'd1);
        chk("single_busy",  32'(busy), 32'd1);
        tick();
        req = 4'b0000;
        chk("single_after_busy", 32'(busy), 32'd0);
        chk("single_after_ptr",  32'(dut.ptr_q), 32'd3);

        // Round-robin from reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        i0 = 8'h10; i1 = 8'h20; i2 = 8'h30; i3 = 8'h40;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("rr_idle_ack", 32'(ack), 32'd0);
            tick();
            $display("rr: grant %0d sel=%0d ack=%b data=%h", n, sel, ack, out_data);
            chk("rr_sel",  32'(sel), 32'(rr_order[n]));
            chk("rr_ack",  32'(ack), 32'(4'b0001 << rr_order[n]));
            chk("rr_data", 32'(out_data), 32'(rr_data[rr_order[n]]));
            tick();
        end
        req = 4'b0000;

        // Lock and back-pressure: ptr is 1, requester 1 sends 11,22,33
        req = 4'b1011; last = 4'b0000; i1 = 8'h11; out_ready = 1'b1;
        tick();
        $display("lock: word 11 sel=%0d ack=%b", sel, ack);
        chk("lock_sel_w0",  32'(sel), 32'd1);
        chk("lock_data_w0", 32'(out_data), 32'h11);
        chk("lock_ack_w0",  32'(ack), 32'b0010);
        tick();
        i1 = 8'h22; out_ready = 1'b0;
        #1;
        chk("lock_stall1_data", 32'(out_data), 32'h22);
        chk("lock_stall1_ack",  32'(ack), 32'd0);
        chk("lock_stall1_vld",  32'(out_valid), 32'd1);
        tick();
        $display("lock: stall sel=%0d data=%h ack=%b", sel, out_data, ack);
        chk("lock_stall2_sel",  32'(sel), 32'd1);
        chk("lock_stall2_data", 32'(out_data), 32'h22);
        chk("lock_stall2_ack",  32'(ack), 32'd0);
        tick();
        out_ready = 1'b1;
        #1;
        chk("lock_w1_ack",  32'(ack), 32'b0010);
        chk("lock_w1_data", 32'(out_data), 32'h22);
        tick();
        i1 = 8'h33; last = 4'b0010;
        #1;
        $display("lock: last word sel=%0d data=%h ack=%b", sel, out_data, ack);
        chk("lock_w2_ack",  32'(ack), 32'b0010);
        chk("lock_w2_last", 32'(out_last), 32'd1);
        chk("lock_w2_sel",  32'(sel), 32'd1);
        tick();
        req = 4'b1001; last = 4'b0000;
        chk("lock_end_busy", 32'(busy), 32'd0);
        chk("lock_end_ptr",  32'(dut.ptr_q), 32'd2);

        // Next grant goes to 3; then requester 3 abandons
        out_ready = 1'b0;
        tick();
        $display("abandon: granted sel=%0d", sel);
        chk("abandon_sel",   32'(sel), 32'd3);
        chk("abandon_valid", 32'(out_valid), 32'd1);
        chk("abandon_ack",   32'(ack), 32'd0);
        tick();
        req = 4'b0001;
        #1;
        chk("abandon_drop_valid", 32'(out_valid), 32'd0);
        chk("abandon_drop_ack",   32'(ack), 32'd0);
        tick();
        chk("abandon_idle_busy", 32'(busy), 32'd0);
        chk("abandon_ptr",       32'(dut.ptr_q), 32'd0);
        tick();
        $display("abandon: next winner sel=%0d", sel);
        chk("abandon_next_sel", 32'(sel), 32'd0);

        // Reset mid-packet with sel=2
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
        tick();
        chk("midrst_pre_sel",  32'(sel), 32'd2);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0110;
        #1;
        $display("midrst: busy=%0d sel=%0d ack=%b", busy, sel, ack);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_sel",   32'(sel), 32'd0);
        chk("midrst_ptr",   32'(dut.ptr_q), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ack",   32'(ack), 32'd0);
        tick();
        chk("midrst_grant", 32'(sel), 32'd1);
        last = 4'b0010;
        tick();
        req = 4'b0000; last = 4'b0000;

        // Idle with no requests, out_ready toggling; sel holds 1
        for (int n = 0; n < 10; n++) begin
            out_ready = n[0];
            #1;
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_ack",   32'(ack), 32'd0);
            chk("idle_busy",  32'(busy), 32'd0);
            chk("idle_sel",   32'(sel), 32'd1);
            tick();
        end
        $display("idle: 10 cycles done, sel=%0d", sel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
